tmr_imu_spi_sampler: RTL and testbench



---
 rtl/tmr_spi_pkg.sv | 23 ++
 rtl/imu_stuck_monitor.sv | 50 +++++
 rtl/tmr_imu_spi_sampler.sv | 203 ++++++++++++++++++++
 tb/tb_tmr_imu_spi_sampler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tmr_spi_pkg
// Description : Shared types and constants for the TMR IMU SPI sampler.
// Revision    : 1.0  initial release
// ============================================================================
package tmr_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_UPDATE = 3'd4
    } state_e;

    localparam logic READ_BIT   = 1'b1;
    localparam int   FRAME_BITS = 16;
    localparam int   DATA_BITS  = 8;
    localparam int   NUM_IMU    = 3;

endpackage
`default_nettype wire

// File: rtl/imu_stuck_monitor.sv
`default_nettype none
// ============================================================================
// Module      : imu_stuck_monitor
// Description : Flags a channel after STUCK_COUNT consecutive 0x00/0xFF bytes.
// Revision    : 1.0  initial release
// ============================================================================
module imu_stuck_monitor
    import tmr_spi_pkg::*;
#(
    parameter int STUCK_COUNT = 8
) (
    input  logic                 clk12MHz,
    input  logic                 rst_n,
    input  logic                 update,
    input  logic [DATA_BITS-1:0] data,
    output logic                 stuck
);

    localparam int               CNT_W   = $clog2(STUCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STUCK_COUNT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (update) begin
            // A rail-level byte is what a floating or shorted MISO line returns.
            if ((data == '0) || (data == '1)) begin
                if (count_q != CNT_MAX) begin
                    count_d = count_q + CNT_W'(1);
                end
            end else begin
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign stuck = (count_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/tmr_imu_spi_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tmr_imu_spi_sampler
// Description : Lockstep SPI reader for three redundant IMUs feeding a voter.
// Revision    : 1.0  initial release
// ============================================================================
module tmr_imu_spi_sampler
    import tmr_spi_pkg::*;
#(
    parameter int         SCLK_DIV    = 6,
    parameter int         SAMPLE_DIV  = 12000,
    parameter logic [6:0] REG_ADDR    = 7'h3B,
    parameter int         STUCK_COUNT = 8
) (
    input  logic       clk12MHz,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       start,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic [2:0] spi_cs_n,
    input  logic [2:0] spi_miso,
    output logic [7:0] imu1,
    output logic [7:0] imu2,
    output logic [7:0] imu3,
    output logic       sample_valid,
    output logic [2:0] stuck,
    output logic       busy,
    output logic       overrun
);

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int GAP_W = $clog2(SCLK_DIV + 1);
    localparam int TMR_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [TMR_W-1:0]      TMR_LAST = TMR_W'(SAMPLE_DIV - 1);
    localparam logic [BIT_W-1:0]      BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [FRAME_BITS-1:0] FRAME    = {READ_BIT, REG_ADDR, {DATA_BITS{1'b0}}};

    state_e                                   state_q, state_d;
    logic [DIV_W-1:0]                         div_q, div_d;
    logic                                     phase_q, phase_d;
    logic [BIT_W-1:0]                         bit_q, bit_d;
    logic [GAP_W-1:0]                         gap_q, gap_d;
    logic [TMR_W-1:0]                         timer_q, timer_d;
    logic [NUM_IMU-1:0][DATA_BITS-1:0]        shift_q, shift_d;
    logic [NUM_IMU-1:0][DATA_BITS-1:0]        imu_q, imu_d;
    logic                                     sclk_q, sclk_d;
    logic                                     mosi_q, mosi_d;
    logic                                     cs_n_q, cs_n_d;
    logic                                     busy_q, busy_d;
    logic                                     sample_valid_q, sample_valid_d;
    logic                                     overrun_q, overrun_d;

    logic tick;
    logic trigger;
    logic accept;
    logic div_last;
    logic frame_active;
    logic load;

    always_comb begin
        tick     = enable && (timer_q == TMR_LAST);
        trigger  = tick || start;
        accept   = trigger && (state_q == ST_IDLE) && (gap_q == '0);
        div_last = (div_q == DIV_LAST);
        timer_d  = (enable && !tick) ? timer_q + TMR_W'(1) : '0;

        state_d = state_q;
        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        gap_d   = (gap_q != '0) ? gap_q - GAP_W'(1) : '0;
        shift_d = shift_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    div_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = '0;
                end
            end
            ST_SETUP: begin
                if (div_last) begin
                    state_d = ST_SHIFT;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SHIFT: begin
                // First cycle of the high half is the rising-edge sample point.
                if (phase_q && (div_q == '0)) begin
                    for (int i = 0; i < NUM_IMU; i++) begin
                        shift_d[i] = {shift_q[i][DATA_BITS-2:0], spi_miso[i]};
                    end
                end
                if (div_last) begin
                    div_d   = '0;
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_HOLD;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_HOLD: begin
                if (div_last) begin
                    state_d = ST_UPDATE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
                gap_d   = GAP_W'(SCLK_DIV);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pin-level outputs are registered from next-state so they never glitch.
        frame_active   = (state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD);
        load           = (state_d == ST_UPDATE);
        cs_n_d         = ~frame_active;
        busy_d         = frame_active;
        sclk_d         = (state_d == ST_SHIFT) && phase_d;
        mosi_d         = ((state_d == ST_SETUP) || (state_d == ST_SHIFT)) ? FRAME[BIT_LAST - bit_d] : 1'b0;
        sample_valid_d = load;
        imu_d          = load ? shift_d : imu_q;
        overrun_d      = trigger && !accept;
    end

    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            div_q          <= '0;
            phase_q        <= 1'b0;
            bit_q          <= '0;
            gap_q          <= '0;
            timer_q        <= '0;
            shift_q        <= '0;
            imu_q          <= '0;
            sclk_q         <= 1'b0;
            mosi_q         <= 1'b0;
            cs_n_q         <= 1'b1;
            busy_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            div_q          <= div_d;
            phase_q        <= phase_d;
            bit_q          <= bit_d;
            gap_q          <= gap_d;
            timer_q        <= timer_d;
            shift_q        <= shift_d;
            imu_q          <= imu_d;
            sclk_q         <= sclk_d;
            mosi_q         <= mosi_d;
            cs_n_q         <= cs_n_d;
            busy_q         <= busy_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    // The stuck counters advance on the same edge that raises sample_valid.
    for (genvar i = 0; i < NUM_IMU; i++) begin : g_chan
        imu_stuck_monitor #(
            .STUCK_COUNT (STUCK_COUNT)
        ) u_stuck_monitor (
            .clk12MHz (clk12MHz),
            .rst_n    (rst_n),
            .update   (load),
            .data     (shift_q[i]),
            .stuck    (stuck[i])
        );
    end

    assign spi_sclk     = sclk_q;
    assign spi_mosi     = mosi_q;
    assign spi_cs_n     = {NUM_IMU{cs_n_q}};
    assign imu1         = imu_q[0];
    assign imu2         = imu_q[1];
    assign imu3         = imu_q[2];
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_tmr_imu_spi_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmr_imu_spi_sampler
// Description : Directed self-checking bench with three SPI IMU models.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tmr_imu_spi_sampler;

    logic       clk12MHz = 1'b0;
    logic       rst_n    = 1'b0;
    logic       enable   = 1'b0;
    logic       start    = 1'b0;
    logic       spi_sclk;
    logic       spi_mosi;
    logic [2:0] spi_cs_n;
    logic [2:0] spi_miso;
    logic [7:0] imu1, imu2, imu3;
    logic       sample_valid;
    logic [2:0] stuck;
    logic       busy;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    logic [15:0] tx [3];

    always #5 clk12MHz = ~clk12MHz;

    tmr_imu_spi_sampler #(
        .SCLK_DIV    (6),
        .SAMPLE_DIV  (400),
        .REG_ADDR    (7'h3B),
        .STUCK_COUNT (8)
    ) dut (
        .clk12MHz     (clk12MHz),
        .rst_n        (rst_n),
        .enable       (enable),
        .start        (start),
        .spi_sclk     (spi_sclk),
        .spi_mosi     (spi_mosi),
        .spi_cs_n     (spi_cs_n),
        .spi_miso     (spi_miso),
        .imu1         (imu1),
        .imu2         (imu2),
        .imu3         (imu3),
        .sample_valid (sample_valid),
        .stuck        (stuck),
        .busy         (busy),
        .overrun      (overrun)
    );

    // Bus observer plus mode-0 slave: MISO advances one bit per SCLK fall.
    logic [4:0]  fcnt        = '0;
    logic        sclk_prev   = 1'b0;
    logic [15:0] mosi_word   = '0;
    int          rises       = 0;
    int          run_len     = 0;
    int          hi_bad      = 0;
    int          lo_bad      = 0;
    int          setup_len   = 0;
    int          cs_low_len  = 0;
    int          cs_high_len = 0;
    int          last_gap    = 0;
    int          frames      = 0;
    int          sv_cnt      = 0;
    int          ov_cnt      = 0;

    assign spi_miso[0] = (!spi_cs_n[0] && !fcnt[4]) ? tx[0][~fcnt[3:0]] : 1'b0;
    assign spi_miso[1] = (!spi_cs_n[1] && !fcnt[4]) ? tx[1][~fcnt[3:0]] : 1'b0;
    assign spi_miso[2] = (!spi_cs_n[2] && !fcnt[4]) ? tx[2][~fcnt[3:0]] : 1'b0;

    always @(posedge clk12MHz) begin
        sclk_prev <= spi_sclk;
        if (sample_valid) sv_cnt <= sv_cnt + 1;
        if (overrun)      ov_cnt <= ov_cnt + 1;
        if (spi_cs_n[0]) begin
            cs_high_len <= cs_high_len + 1;
            cs_low_len  <= 0;
            fcnt        <= '0;
        end else begin
            cs_low_len <= cs_low_len + 1;
            if (cs_low_len == 0) begin
                frames      <= frames + 1;
                last_gap    <= cs_high_len;
                cs_high_len <= 0;
                rises       <= 0;
                run_len     <= 1;
            end else if (spi_sclk != sclk_prev) begin
                run_len <= 1;
                if (spi_sclk) begin
                    rises     <= rises + 1;
                    mosi_word <= {mosi_word[14:0], spi_mosi};
                    if (rises == 0) setup_len <= cs_low_len;
                    else if (run_len != 6) lo_bad <= lo_bad + 1;
                end else begin
                    fcnt <= fcnt + 5'd1;
                    if (run_len != 6) hi_bad <= hi_bad + 1;
                end
            end else begin
                run_len <= run_len + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk12MHz);
        #1;
    endtask

    // Trigger in cycle T with start, optionally inject a second start at T+inject,
    // and return positioned in cycle T+205 where sample_valid must be high.
    task automatic run_frame(input int inject);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("frame_cs_low", {29'd0, spi_cs_n}, 32'd0);
        chk("frame_busy", {31'd0, busy}, 32'd1);
        if (inject > 0) begin
            cyc(inject - 1);
            start = 1'b1;
            cyc(1);
            start = 1'b0;
            chk("overrun_pulse", {31'd0, overrun}, 32'd1);
            cyc(1);
            chk("overrun_clear", {31'd0, overrun}, 32'd0);
            cyc(202 - inject);
        end else begin
            cyc(203);
        end
        chk("valid_not_early", {31'd0, sample_valid}, 32'd0);
        cyc(1);
        chk("valid_at_205", {31'd0, sample_valid}, 32'd1);
        chk("busy_fall", {31'd0, busy}, 32'd0);
        chk("cs_release", {29'd0, spi_cs_n}, 32'h7);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int ov0;
        int sv0;
        int got;

        tx[0] = 16'h0004;
        tx[1] = 16'h0004;
        tx[2] = 16'h0040;
        cyc(3);

        chk("rst_cs_n", {29'd0, spi_cs_n}, 32'h7);
        chk("rst_imu", {8'd0, imu1, imu2, imu3}, 32'd0);
        chk("rst_ctrl", {24'd0, sample_valid, busy, overrun, stuck, spi_sclk, spi_mosi}, 32'd0);
        rst_n = 1'b1;
        cyc(4);

        // Basic read
        run_frame(0);
        chk("basic_imu1", {24'd0, imu1}, 32'h04);
        chk("basic_imu2", {24'd0, imu2}, 32'h04);
        chk("basic_imu3", {24'd0, imu3}, 32'h40);
        cyc(2);
        chk("mosi_frame", {16'd0, mosi_word}, 32'hBB00);
        chk("sclk_rises", rises, 32'd16);
        chk("setup_ge6", {31'd0, setup_len >= 6}, 32'd1);

        // Trigger inside the CS-high gap is dropped
        cyc(3);
        f0 = frames;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("gap_overrun", {31'd0, overrun}, 32'd1);
        chk("gap_no_busy", {31'd0, busy}, 32'd0);
        cyc(10);
        chk("gap_no_frame", frames, f0);

        // Sign handling
        tx[1] = 16'h00F0;
        run_frame(0);
        chk("sign_imu2", {24'd0, imu2}, 32'hF0);
        chk("sign_neg16", {31'd0, $signed(imu2) == -16}, 32'd1);
        chk("sign_not_stuck", {31'd0, stuck[1]}, 32'd0);
        chk("imu1_held", {24'd0, imu1}, 32'h04);
        cyc(2);
        chk("cs_gap_ge6", {31'd0, last_gap >= 6}, 32'd1);
        cyc(6);

        // start while busy
        f0 = frames;
        run_frame(50);
        cyc(8);
        chk("busy_one_frame", frames, f0 + 1);

        // Stuck channel 3
        tx[2] = 16'hFFFF;
        for (int k = 1; k <= 8; k++) begin
            run_frame(0);
            chk("stuck_run", {31'd0, stuck[2]}, {31'd0, k == 8});
            cyc(8);
        end
        chk("stuck_imu3_ff", {24'd0, imu3}, 32'hFF);
        chk("stuck_others", {30'd0, stuck[1:0]}, 32'd0);
        tx[2] = 16'h0010;
        run_frame(0);
        chk("stuck_clear", {31'd0, stuck[2]}, 32'd0);
        chk("clear_imu3", {24'd0, imu3}, 32'h10);
        cyc(8);

        // Reset during SHIFT bit 5 (high half)
        sv0 = sv_cnt;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(74);
        chk("bit5_sclk_high", {31'd0, spi_sclk}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_cs_n", {29'd0, spi_cs_n}, 32'h7);
        chk("arst_sclk", {31'd0, spi_sclk}, 32'd0);
        chk("arst_imu", {8'd0, imu1, imu2, imu3}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        cyc(3);
        rst_n = 1'b1;
        cyc(300);
        chk("arst_no_valid", sv_cnt, sv0);

        // start coincident with a timer tick
        f0  = frames;
        ov0 = ov_cnt;
        enable = 1'b1;
        cyc(399);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("tick_start_cs", {29'd0, spi_cs_n}, 32'd0);
        chk("tick_start_no_ovr", {31'd0, overrun}, 32'd0);
        cyc(210);
        chk("tick_start_frames", frames, f0 + 1);
        chk("tick_start_ovr_cnt", ov_cnt, ov0);

        // enable dropped mid-frame
        got = 0;
        for (int k = 0; k < 400 && got == 0; k++) begin
            cyc(1);
            if (busy) got = 1;
        end
        chk("tick_frame_start", got, 32'd1);
        cyc(20);
        enable = 1'b0;
        got = 0;
        for (int k = 0; k < 300 && got == 0; k++) begin
            cyc(1);
            if (sample_valid) got = 1;
        end
        chk("disable_frame_done", got, 32'd1);
        f0 = frames;
        cyc(1000);
        chk("no_more_ticks", frames, f0);

        chk("sclk_high_half", hi_bad, 32'd0);
        chk("sclk_low_half", lo_bad, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
